// File: rtl/signal_debouncer.sv
// Synchronizer plus qualify-then-accept debouncer with rise/fall pulses.
// Define SIGNAL_DEBOUNCER_GLITCH_COUNT_EN to add the glitch_count port.
module signal_debouncer #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        raw_in,
  output logic        signal,
  output logic        rise,
  output logic        fall,
  output logic        busy
`ifdef SIGNAL_DEBOUNCER_GLITCH_COUNT_EN
  ,
  output logic [15:0] glitch_count
`endif
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE_LOW,
    QUAL_HIGH,
    IDLE_HIGH,
    QUAL_LOW
  } state_t;

  logic [SYNC_STAGES-1:0] sync_chain_q, sync_chain_d;
  logic                   sync_q;
  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   signal_q, signal_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   busy_q, busy_d;

  assign sync_q = sync_chain_q[SYNC_STAGES-1];
  assign sync_chain_d = {sync_chain_q[SYNC_STAGES-2:0], raw_in};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    signal_d = signal_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    unique case (state_q)
      IDLE_LOW: begin
        if (sync_q) begin
          if (STABLE_CYCLES == 1) begin
            state_d  = IDLE_HIGH;
            signal_d = 1'b1;
            rise_d   = 1'b1;
          end else begin
            state_d = QUAL_HIGH;
            cnt_d   = CW'(1);
          end
        end
      end
      QUAL_HIGH: begin
        if (!sync_q) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d  = IDLE_HIGH;
          cnt_d    = '0;
          signal_d = 1'b1;
          rise_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE_HIGH: begin
        if (!sync_q) begin
          if (STABLE_CYCLES == 1) begin
            state_d  = IDLE_LOW;
            signal_d = 1'b0;
            fall_d   = 1'b1;
          end else begin
            state_d = QUAL_LOW;
            cnt_d   = CW'(1);
          end
        end
      end
      QUAL_LOW: begin
        if (sync_q) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d  = IDLE_LOW;
          cnt_d    = '0;
          signal_d = 1'b0;
          fall_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
    busy_d = (state_d == QUAL_HIGH) || (state_d == QUAL_LOW);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_chain_q <= '0;
      state_q      <= IDLE_LOW;
      cnt_q        <= '0;
      signal_q     <= 1'b0;
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      sync_chain_q <= sync_chain_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      signal_q     <= signal_d;
      rise_q       <= rise_d;
      fall_q       <= fall_d;
      busy_q       <= busy_d;
    end
  end

  assign signal = signal_q;
  assign rise   = rise_q;
  assign fall   = fall_q;
  assign busy   = busy_q;

`ifdef SIGNAL_DEBOUNCER_GLITCH_COUNT_EN
  logic        abort;
  logic [15:0] glitch_q, glitch_d;

  // An abort is a qualifying candidate falling back to the held level.
  assign abort = ((state_q == QUAL_HIGH) && !sync_q) ||
                 ((state_q == QUAL_LOW) && sync_q);

  always_comb begin
    glitch_d = glitch_q;
    if (abort && (glitch_q != 16'hFFFF)) glitch_d = glitch_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) glitch_q <= '0;
    else       glitch_q <= glitch_d;
  end

  assign glitch_count = glitch_q;
`endif

endmodule

// File: tb/tb_signal_debouncer.sv
// Randomized self-checking bench for signal_debouncer against a
// run-length reference model of the debounce rules.
module tb_signal_debouncer;

  localparam int S = 2;
  localparam int N = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic raw_in = 1'b0;
  logic signal, rise, fall, busy;
`ifdef SIGNAL_DEBOUNCER_GLITCH_COUNT_EN
  logic [15:0] glitch_count;
`endif

  always #5 clk = ~clk;

  signal_debouncer #(.SYNC_STAGES(S), .STABLE_CYCLES(N)) dut (
    .clk(clk),
    .reset(reset),
    .raw_in(raw_in),
    .signal(signal),
    .rise(rise),
    .fall(fall),
    .busy(busy)
`ifdef SIGNAL_DEBOUNCER_GLITCH_COUNT_EN
    ,
    .glitch_count(glitch_count)
`endif
  );

  int checks = 0;
  int failures = 0;

  bit pipe[$];
  bit m_sig, m_rise, m_fall, m_busy;
  int run_len;
  int m_glitch;

  // Model: signal flips once N consecutive synchronized samples differ
  // from it; a differing run broken early is one glitch.
  task automatic model_step(input bit r, input bit rs);
    bit s;
    m_rise = 0;
    m_fall = 0;
    if (rs) begin
      pipe.delete();
      for (int i = 0; i < S; i++) pipe.push_back(1'b0);
      m_sig = 0;
      run_len = 0;
      m_glitch = 0;
    end else begin
      pipe.push_front(r);
      s = pipe.pop_back();
      if (s != m_sig) begin
        run_len++;
        if (run_len == N) begin
          m_sig = s;
          m_rise = s;
          m_fall = !s;
          run_len = 0;
        end
      end else begin
        if (run_len > 0 && m_glitch < 65535) m_glitch++;
        run_len = 0;
      end
    end
    m_busy = (run_len > 0);
  endtask

  task automatic tick(input bit r, input bit rs);
    @(negedge clk);
    raw_in = r;
    reset = rs;
    @(posedge clk);
    model_step(r, rs);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'b0);
      checks++;
      if ({signal, rise, fall, busy} !== 4'b0000) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d got=%b exp=0000", i,
                 {signal, rise, fall, busy});
      end
    end
`ifdef SIGNAL_DEBOUNCER_GLITCH_COUNT_EN
    checks++;
    if (glitch_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_glitch got=%0d exp=0", glitch_count);
    end
`endif
  endtask

  task automatic test_rise();
    int first, rises, falls, busys;
    first = 0; rises = 0; falls = 0; busys = 0;
    for (int i = 1; i <= 40; i++) begin
      tick(1'b1, 1'b0);
      if (signal === 1'b1 && first == 0) first = i;
      if (rise === 1'b1) rises++;
      if (fall === 1'b1) falls++;
      if (busy === 1'b1) busys++;
      checks++;
      if ({signal, rise, fall, busy} !==
          {m_sig, m_rise, m_fall, m_busy}) begin
        failures++;
        $display("FAIL rise_trace cyc=%0d got=%b exp=%b", i,
                 {signal, rise, fall, busy},
                 {m_sig, m_rise, m_fall, m_busy});
      end
    end
    checks++;
    if (first != S + N) begin
      failures++;
      $display("FAIL rise_latency got=%0d exp=%0d", first, S + N);
    end
    checks++;
    if (rises != 1 || falls != 0) begin
      failures++;
      $display("FAIL rise_pulses got=%0d/%0d exp=1/0", rises, falls);
    end
    checks++;
    if (busys != N - 1) begin
      failures++;
      $display("FAIL rise_busy got=%0d exp=%0d", busys, N - 1);
    end
  endtask

  task automatic test_glitch();
    int pulses;
    pulses = 0;
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      tick(i < 5, 1'b0);
      if (rise === 1'b1 || fall === 1'b1) pulses++;
      checks++;
      if ({signal, rise, fall, busy} !==
          {m_sig, m_rise, m_fall, m_busy}) begin
        failures++;
        $display("FAIL glitch_trace cyc=%0d got=%b exp=%b", i,
                 {signal, rise, fall, busy},
                 {m_sig, m_rise, m_fall, m_busy});
      end
    end
    checks++;
    if (signal !== 1'b0 || pulses != 0) begin
      failures++;
      $display("FAIL glitch_level got=%b/%0d exp=0/0", signal, pulses);
    end
`ifdef SIGNAL_DEBOUNCER_GLITCH_COUNT_EN
    checks++;
    if (glitch_count !== 16'd1 || m_glitch != 1) begin
      failures++;
      $display("FAIL glitch_count got=%0d exp=1 model=%0d",
               glitch_count, m_glitch);
    end
`endif
  endtask

  task automatic test_reset_mid();
    int first, rises;
    first = 0; rises = 0;
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
    for (int i = 0; i < S + 10; i++) begin
      tick(1'b1, 1'b0);
      if (rise === 1'b1) rises++;
    end
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_qual_busy got=%b exp=1", busy);
    end
    tick(1'b1, 1'b1);
    checks++;
    if ({signal, rise, fall, busy} !== 4'b0000 || rises != 0) begin
      failures++;
      $display("FAIL mid_reset got=%b/%0d exp=0000/0",
               {signal, rise, fall, busy}, rises);
    end
`ifdef SIGNAL_DEBOUNCER_GLITCH_COUNT_EN
    checks++;
    if (glitch_count !== 16'd0) begin
      failures++;
      $display("FAIL mid_reset_glitch got=%0d exp=0", glitch_count);
    end
`endif
    for (int i = 1; i <= 30; i++) begin
      tick(1'b1, 1'b0);
      if (signal === 1'b1 && first == 0) first = i;
      if (rise === 1'b1) rises++;
      checks++;
      if ({signal, rise, fall, busy} !==
          {m_sig, m_rise, m_fall, m_busy}) begin
        failures++;
        $display("FAIL mid_release cyc=%0d got=%b exp=%b", i,
                 {signal, rise, fall, busy},
                 {m_sig, m_rise, m_fall, m_busy});
      end
    end
    checks++;
    if (first != S + N || rises != 1) begin
      failures++;
      $display("FAIL mid_release_latency got=%0d/%0d exp=%0d/1",
               first, rises, S + N);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 5; r++) begin
      int cyc, pos, neg, rc, fc, m_rc, m_fc;
      bit prev, lvl;
      cyc = 0; pos = 0; neg = 0; rc = 0; fc = 0; m_rc = 0; m_fc = 0;
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
      prev = 1'b0;
      while (cyc < 1000) begin
        int hold;
        hold = $urandom_range(1, 40);
        lvl = 1'($urandom_range(0, 1));
        for (int h = 0; h < hold && cyc < 1000; h++) begin
          tick(lvl, 1'b0);
          cyc++;
          if (signal === 1'b1 && !prev) pos++;
          if (signal === 1'b0 && prev) neg++;
          prev = (signal === 1'b1);
          if (rise === 1'b1) rc++;
          if (fall === 1'b1) fc++;
          if (m_rise) m_rc++;
          if (m_fall) m_fc++;
          checks++;
          if ({signal, rise, fall, busy} !==
              {m_sig, m_rise, m_fall, m_busy}) begin
            failures++;
            if (failures < 20)
              $display("FAIL rand_trace run=%0d cyc=%0d got=%b exp=%b",
                       r, cyc, {signal, rise, fall, busy},
                       {m_sig, m_rise, m_fall, m_busy});
          end
        end
      end
      checks++;
      if (pos != rc || neg != fc || rc != m_rc || fc != m_fc) begin
        failures++;
        $display("FAIL rand_edges run=%0d pos=%0d rise=%0d neg=%0d fall=%0d exp=%0d/%0d",
                 r, pos, rc, neg, fc, m_rc, m_fc);
      end
`ifdef SIGNAL_DEBOUNCER_GLITCH_COUNT_EN
      checks++;
      if (glitch_count !== 16'(m_glitch)) begin
        failures++;
        $display("FAIL rand_glitch run=%0d got=%0d exp=%0d",
                 r, glitch_count, m_glitch);
      end
`endif
    end
  endtask

  initial begin
    for (int i = 0; i < S; i++) pipe.push_back(1'b0);
    test_reset();
    test_rise();
    test_glitch();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/signal_debouncer.md
SIGNAL_DEBOUNCER -- requirements
Module: signal_debouncer

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops (legal >= 2).
REQ-002 The block SHALL have parameter STABLE_CYCLES, default 16, consecutive synchronized samples needed to accept a new level (legal >= 1).
REQ-003 The block SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port raw_in  input  1  asynchronous, possibly bouncing input.
REQ-006 The block SHALL have port signal  output  1  registered debounced level, suitable as edge-counter input.
REQ-007 The block SHALL have port rise  output  1  one-cycle pulse in the cycle signal first reads 1.
REQ-008 The block SHALL have port fall  output  1  one-cycle pulse in the cycle signal first reads 0.
REQ-009 The block SHALL have port busy  output  1  high while a candidate level is qualifying.
REQ-010 The block SHALL have port glitch_count  output  16  rejected-transition count (present only per REQ-027).

Function
REQ-011 raw_in SHALL pass through a SYNC_STAGES-deep flop chain; only the last stage (sync_q) feeds the FSM.
REQ-012 The FSM SHALL have states IDLE_LOW, QUAL_HIGH, IDLE_HIGH, QUAL_LOW; signal=0 in IDLE_LOW/QUAL_HIGH, 1 in IDLE_HIGH/QUAL_LOW.
REQ-013 IDLE_LOW with sync_q=1 SHALL go to QUAL_HIGH with stable counter=1; IDLE_HIGH with sync_q=0 SHALL go to QUAL_LOW with counter=1.
REQ-014 In QUAL_x, sync_q equal to candidate SHALL increment the counter; on the sample that makes STABLE_CYCLES consecutive matches, the FSM SHALL enter IDLE_x and flip signal.
REQ-015 STABLE_CYCLES=1 SHALL flip signal on the first differing sample, going directly IDLE_LOW->IDLE_HIGH (or reverse) without a QUAL state.
REQ-016 In QUAL_x, sync_q returning to the current signal level SHALL abort to the originating IDLE state, clear the counter, leave signal unchanged, emit no pulse.
REQ-017 Latency: counting the first edge sampling the new stable raw_in level as edge 1, signal SHALL change after edge SYNC_STAGES+STABLE_CYCLES (edge 18 at defaults).
REQ-018 rise/fall SHALL be registered, asserted for exactly the first cycle of the new signal level, never both, never back-to-back on the same level.
REQ-019 Every 0->1 of signal SHALL coincide with one rise pulse and every 1->0 with one fall pulse; counts are always equal to signal edge counts.
REQ-020 busy SHALL be 1 exactly in QUAL_HIGH/QUAL_LOW.
REQ-021 Stable counter width SHALL be $clog2(STABLE_CYCLES+1); it SHALL never wrap.

Reset
REQ-022 reset SHALL clear all sync flops to 0, state to IDLE_LOW, counter to 0, signal/rise/fall/busy to 0, glitch_count to 0 on the same rising edge.
REQ-023 reset asserted mid-qualification SHALL abandon the candidate; no rise/fall pulse and no glitch increment occur from that attempt.
REQ-024 reset SHALL dominate all other conditions in the same cycle.
REQ-025 After reset release with raw_in=1, signal SHALL rise per REQ-017 as an ordinary transition.

Configuration
REQ-026 Macro SIGNAL_DEBOUNCER_GLITCH_COUNT_EN SHALL control the glitch counter.
REQ-027 With the macro defined, glitch_count port and logic SHALL exist; each REQ-016 abort SHALL increment it by 1, saturating at 16'hFFFF.
REQ-028 Without the macro, the glitch_count port and logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-029 Defaults, reset 3 cycles, raw_in=0 for 20 cycles -> signal=0, rise=fall=busy=0, glitch_count=0.
REQ-030 raw_in 0->1 held 40 cycles -> signal=1 after edge 18, rise high exactly that one cycle, fall never high, busy high 15 cycles before.
REQ-031 raw_in high 5 cycles then low -> signal stays 0, no pulses, glitch_count=1.
REQ-032 reset asserted 10 cycles into QUAL_HIGH -> signal=0, no rise pulse, busy=0, glitch_count unchanged after reset.
REQ-033 5 runs x 1000 cycles of random raw_in holds (1..40 cycles), signal driving the edge counter -> edge counter posedge/negedge counts equal bench-counted rise/fall pulses.
REQ-034 Rebuild without SIGNAL_DEBOUNCER_GLITCH_COUNT_EN, rerun REQ-029..REQ-033 minus glitch checks -> identical signal/rise/fall/busy traces.
